// File: rtl/instruction_fetch.sv
// MicroUAZ fetch stage: req/ack program-memory read into an instruction register, valid/ready to the decoder.
// Optional macro FETCH_TIMEOUT_EN adds a sticky REQ timeout with an ERR state.
module instruction_fetch #(
    parameter int ADDR_W         = 9,
    parameter int INSTR_W        = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic [ADDR_W-1:0]  i_Address_Bus,
    output logic [ADDR_W-1:0]  o_Mem_Addr,
    output logic               o_Mem_Req,
    input  logic               i_Mem_Ack,
    input  logic [INSTR_W-1:0] i_Mem_Data,
    output logic [INSTR_W-1:0] o_Instr,
    output logic [4:0]         o_Opcode,
    output logic [2:0]         o_Reg,
    output logic [7:0]         o_Imm,
    output logic               o_Instr_Valid,
    input  logic               i_Instr_Ready,
    input  logic               i_Flush,
    output logic               o_Pc_Advance,
    output logic               o_Fetch_Error
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_FULL = 3'd2,
        ST_ADV  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             err_r, err_s;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_FULL = 3'd2,
        ST_ADV  = 3'd3
    } state_t;
`endif

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic               req_r, req_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic               valid_r, valid_s;
    logic               adv_r, adv_s;
    logic               discard_r, discard_s;

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        req_s     = req_r;
        instr_s   = instr_r;
        valid_s   = valid_r;
        adv_s     = adv_r;
        discard_s = discard_r;
`ifdef FETCH_TIMEOUT_EN
        cnt_s     = cnt_r;
        err_s     = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                addr_s  = i_Address_Bus;
                req_s   = 1'b1;
                state_s = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                cnt_s   = '0;
`endif
            end
            ST_REQ: begin
                if (i_Mem_Ack) begin
                    req_s = 1'b0;
                    // A flush arriving with the ack discards that very word.
                    if (discard_r || i_Flush) begin
                        discard_s = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        instr_s = i_Mem_Data;
                        valid_s = 1'b1;
                        state_s = ST_FULL;
                    end
                end else begin
                    if (i_Flush) begin
                        discard_s = 1'b1;
                    end else begin
                        discard_s = discard_r;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        req_s   = 1'b0;
                        err_s   = 1'b1;
                        state_s = ST_ERR;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
`endif
                end
            end
            ST_FULL: begin
                if (i_Flush) begin
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end else if (i_Instr_Ready) begin
                    valid_s = 1'b0;
                    adv_s   = 1'b1;
                    state_s = ST_ADV;
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_ADV: begin
                adv_s   = 1'b0;
                state_s = ST_IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            ST_ERR: begin
                state_s = ST_ERR;
            end
`endif
            default: begin
                state_s   = ST_IDLE;
                req_s     = 1'b0;
                valid_s   = 1'b0;
                adv_s     = 1'b0;
                discard_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            req_r     <= 1'b0;
            instr_r   <= '0;
            valid_r   <= 1'b0;
            adv_r     <= 1'b0;
            discard_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_r     <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            req_r     <= req_s;
            instr_r   <= instr_s;
            valid_r   <= valid_s;
            adv_r     <= adv_s;
            discard_r <= discard_s;
`ifdef FETCH_TIMEOUT_EN
            cnt_r     <= cnt_s;
            err_r     <= err_s;
`endif
        end
    end

    assign o_Mem_Addr    = addr_r;
    assign o_Mem_Req     = req_r;
    assign o_Instr       = instr_r;
    assign o_Instr_Valid = valid_r;
    assign o_Pc_Advance  = adv_r;
    assign o_Opcode      = instr_r[15:11];
    assign o_Reg         = instr_r[10:8];
    assign o_Imm         = instr_r[7:0];
`ifdef FETCH_TIMEOUT_EN
    assign o_Fetch_Error = err_r;
`else
    assign o_Fetch_Error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; inputs change on negedge, outputs sampled on negedge.
module tb_instruction_fetch;
    logic        clk_s = 1'b0;
    logic        rst_s;
    logic [8:0]  pc_s;
    logic [8:0]  mem_addr_s;
    logic        mem_req_s;
    logic        ack_s;
    logic [15:0] data_s;
    logic [15:0] instr_s;
    logic [4:0]  opcode_s;
    logic [2:0]  reg_s;
    logic [7:0]  imm_s;
    logic        valid_s;
    logic        ready_s;
    logic        flush_s;
    logic        adv_s;
    logic        err_s;

    int total_cnt = 0;
    int bad_cnt   = 0;

    instruction_fetch dut (
        .i_Clk         (clk_s),
        .i_Reset       (rst_s),
        .i_Address_Bus (pc_s),
        .o_Mem_Addr    (mem_addr_s),
        .o_Mem_Req     (mem_req_s),
        .i_Mem_Ack     (ack_s),
        .i_Mem_Data    (data_s),
        .o_Instr       (instr_s),
        .o_Opcode      (opcode_s),
        .o_Reg         (reg_s),
        .o_Imm         (imm_s),
        .o_Instr_Valid (valid_s),
        .i_Instr_Ready (ready_s),
        .i_Flush       (flush_s),
        .o_Pc_Advance  (adv_s),
        .o_Fetch_Error (err_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_s);
        @(negedge clk_s);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(mem_req_s),  32'd0);
        chk({tag, "_addr"},  32'(mem_addr_s), 32'd0);
        chk({tag, "_instr"}, 32'(instr_s),    32'd0);
        chk({tag, "_valid"}, 32'(valid_s),    32'd0);
        chk({tag, "_adv"},   32'(adv_s),      32'd0);
        chk({tag, "_err"},   32'(err_s),      32'd0);
    endtask

    initial begin
        rst_s = 1'b1; pc_s = 9'h005; ack_s = 1'b0; data_s = 16'h0000;
        ready_s = 1'b0; flush_s = 1'b0;
        repeat (3) @(negedge clk_s);
        chk_reset_vals("rst");

        // Ack held from release: ignored in IDLE, sampled on first REQ cycle.
        rst_s = 1'b0; ack_s = 1'b1; data_s = 16'hA83C;
        step();
        chk("e1_req",  32'(mem_req_s),  32'd1);
        chk("e1_addr", 32'(mem_addr_s), 32'h005);
        chk("e1_valid", 32'(valid_s),   32'd0);
        step();
        ack_s = 1'b0;
        chk("e2_valid",  32'(valid_s),  32'd1);
        chk("e2_req",    32'(mem_req_s), 32'd0);
        chk("e2_opcode", 32'(opcode_s), 32'h15);
        chk("e2_reg",    32'(reg_s),    32'h0);
        chk("e2_imm",    32'(imm_s),    32'h3C);

        // Decoder stalls 5 cycles.
        pc_s = 9'h006; data_s = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", 32'(instr_s), 32'hA83C);
            chk("stall_valid", 32'(valid_s), 32'd1);
            chk("stall_adv",   32'(adv_s),   32'd0);
        end
        ready_s = 1'b1;
        step();
        ready_s = 1'b0;
        chk("m_valid", 32'(valid_s), 32'd0);
        chk("m_adv",   32'(adv_s),   32'd1);
        step();
        chk("m1_adv", 32'(adv_s),     32'd0);
        chk("m1_req", 32'(mem_req_s), 32'd0);
        step();
        chk("m2_req",  32'(mem_req_s),  32'd1);
        chk("m2_addr", 32'(mem_addr_s), 32'h006);

        // Ack delayed 3 cycles: request held 4 cycles with stable address.
        pc_s = 9'h0AA; data_s = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req",  32'(mem_req_s),  32'd1);
            chk("wait_addr", 32'(mem_addr_s), 32'h006);
        end
        ack_s = 1'b1;
        step();
        ack_s = 1'b0;
        chk("dly_req",   32'(mem_req_s), 32'd0);
        chk("dly_valid", 32'(valid_s),   32'd1);
        chk("dly_instr", 32'(instr_s),   32'h1234);
        ready_s = 1'b1;
        step();
        ready_s = 1'b0;
        chk("dly_adv", 32'(adv_s), 32'd1);
        pc_s = 9'h007;
        step();
        step();
        chk("n_req",  32'(mem_req_s),  32'd1);
        chk("n_addr", 32'(mem_addr_s), 32'h007);

        // Flush in REQ before ack: acked word dropped, new request follows.
        flush_s = 1'b1;
        step();
        flush_s = 1'b0;
        chk("fr_req",   32'(mem_req_s), 32'd1);
        chk("fr_valid", 32'(valid_s),   32'd0);
        ack_s = 1'b1; data_s = 16'hBEEF;
        step();
        ack_s = 1'b0;
        chk("fr_ack_req",   32'(mem_req_s), 32'd0);
        chk("fr_ack_valid", 32'(valid_s),   32'd0);
        chk("fr_ack_instr", 32'(instr_s),   32'h1234);
        step();
        chk("fr_new_req",   32'(mem_req_s), 32'd1);
        chk("fr_new_valid", 32'(valid_s),   32'd0);

        // Flush together with ready in FULL: no advance, back to IDLE.
        ack_s = 1'b1; data_s = 16'h5555;
        step();
        ack_s = 1'b0;
        chk("ff_valid", 32'(valid_s), 32'd1);
        flush_s = 1'b1; ready_s = 1'b1;
        step();
        flush_s = 1'b0; ready_s = 1'b0;
        chk("ff_valid0", 32'(valid_s), 32'd0);
        chk("ff_adv",    32'(adv_s),   32'd0);
        step();
        chk("ff_adv2",  32'(adv_s),     32'd0);
        chk("ff_reqd",  32'(mem_req_s), 32'd1);

        // Flush together with ack in REQ: data discarded.
        flush_s = 1'b1; ack_s = 1'b1; data_s = 16'h7777;
        step();
        flush_s = 1'b0; ack_s = 1'b0;
        chk("fa_valid", 32'(valid_s),   32'd0);
        chk("fa_req",   32'(mem_req_s), 32'd0);
        chk("fa_instr", 32'(instr_s),   32'h5555);
        step();
        chk("fa_req2", 32'(mem_req_s), 32'd1);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step();
        chk("to_req14", 32'(mem_req_s), 32'd1);
        chk("to_err14", 32'(err_s),     32'd0);
        step();
        chk("to_req", 32'(mem_req_s), 32'd0);
        chk("to_err", 32'(err_s),     32'd1);
        ack_s = 1'b1; flush_s = 1'b1;
        repeat (5) step();
        ack_s = 1'b0; flush_s = 1'b0;
        chk("err_hold_err",   32'(err_s),     32'd1);
        chk("err_hold_req",   32'(mem_req_s), 32'd0);
        chk("err_hold_valid", 32'(valid_s),   32'd0);
`else
        for (int i = 0; i < 100; i++) step();
        chk("noto_req", 32'(mem_req_s), 32'd1);
        chk("noto_err", 32'(err_s),     32'd0);
`endif

        // Reset mid-operation, then an ack after release while req is low is ignored.
        rst_s = 1'b1;
        #2;
        chk_reset_vals("mid_rst");
        @(negedge clk_s);
        pc_s = 9'h123; ack_s = 1'b1; data_s = 16'hCAFE;
        rst_s = 1'b0;
        step();
        chk("rel_req",   32'(mem_req_s),  32'd1);
        chk("rel_addr",  32'(mem_addr_s), 32'h123);
        chk("rel_valid", 32'(valid_s),    32'd0);
        chk("rel_instr", 32'(instr_s),    32'h0000);
        step();
        ack_s = 1'b0;
        chk("rel_valid2", 32'(valid_s), 32'd1);
        chk("rel_instr2", 32'(instr_s), 32'hCAFE);
        chk("rel_err",    32'(err_s),   32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
